// File: rtl/bcd_vote_converter_if.sv
// Handshake and digit bundle between the vote tally logic and the BCD converter.
// The master requests conversions and consumes the digits; the slave is the converter.
interface bcd_vote_converter_if #(
    parameter int BIN_WIDTH = 14
);
    logic                 start;
    logic [BIN_WIDTH-1:0] bin_in;
    logic                 busy;
    logic                 done;
    logic                 overflow;
    logic [3:0]           ones;
    logic [3:0]           tens;
    logic [3:0]           hundreds;
    logic [3:0]           thousands;

    modport master (
        output start, bin_in,
        input  busy, done, overflow, ones, tens, hundreds, thousands
    );

    modport slave (
        input  start, bin_in,
        output busy, done, overflow, ones, tens, hundreds, thousands
    );
endinterface

// File: rtl/bcd_vote_converter.sv
// Sequential double-dabble binary-to-BCD converter feeding the 4-digit display.
// Digits are registered and only change on the done edge, so the display never sees partial results.
module bcd_vote_converter #(
    parameter int BIN_WIDTH = 14
) (
    input logic                 clk_100MHz,
    input logic                 reset_n,
    bcd_vote_converter_if.slave bus
);
    localparam int SCR_W = 16 + BIN_WIDTH;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [SCR_W-1:0] scratch;
    logic [SCR_W-1:0] adjusted;
    logic [CNT_W-1:0] count;
    logic             ovf_pending;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (count == CNT_W'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);

    // Add-3 stays inside each nibble; the 4-bit sum wraps so no carry reaches the neighbour.
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[BIN_WIDTH + 4*i +: 4] >= 4'd5)
                adjusted[BIN_WIDTH + 4*i +: 4] = scratch[BIN_WIDTH + 4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            scratch       <= '0;
            count         <= '0;
            ovf_pending   <= 1'b0;
            bus.done      <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.ones      <= 4'd0;
            bus.tens      <= 4'd0;
            bus.hundreds  <= 4'd0;
            bus.thousands <= 4'd0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        scratch     <= {16'd0, bus.bin_in};
                        count       <= CNT_W'(BIN_WIDTH);
                        ovf_pending <= (32'(bus.bin_in) > 32'd9999);
                    end
                end
                SHIFT: begin
                    scratch <= adjusted << 1;
                    count   <= count - CNT_W'(1);
                end
                DONE: begin
                    // Out-of-range values blank the display with all-F digits.
                    bus.done     <= 1'b1;
                    bus.overflow <= ovf_pending;
                    if (ovf_pending) begin
                        bus.thousands <= 4'hF;
                        bus.hundreds  <= 4'hF;
                        bus.tens      <= 4'hF;
                        bus.ones      <= 4'hF;
                    end else begin
                        bus.thousands <= scratch[SCR_W-1  -: 4];
                        bus.hundreds  <= scratch[SCR_W-5  -: 4];
                        bus.tens      <= scratch[SCR_W-9  -: 4];
                        bus.ones      <= scratch[SCR_W-13 -: 4];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_vote_converter.sv
// Directed self-checking bench for bcd_vote_converter with a div/mod reference for the digits.
module tb_bcd_vote_converter;
    localparam int BIN_WIDTH = 14;
    localparam int LATENCY   = BIN_WIDTH + 1;
    localparam int BUDGET    = 40;

    logic clk_100MHz = 1'b0;
    logic reset_n    = 1'b0;
    int   check_count = 0;
    int   error_count = 0;
    logic [15:0] last_digits = 16'h0000;
    logic [15:0] digits_obs;
    int   latency;

    bcd_vote_converter_if #(.BIN_WIDTH(BIN_WIDTH)) bus ();

    bcd_vote_converter #(.BIN_WIDTH(BIN_WIDTH)) dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .bus        (bus)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    assign digits_obs = {bus.thousands, bus.hundreds, bus.tens, bus.ones};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen, with start/bin_in left as given.
    task automatic applyStimulus(input int value, input logic keep_start, input int mid_value, output int lat);
        logic stable;
        logic busy_ok;
        stable  = 1'b1;
        busy_ok = 1'b1;
        lat     = 0;
        bus.start  = 1'b1;
        bus.bin_in = BIN_WIDTH'(value);
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        if (!keep_start) bus.start = 1'b0;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) busy_ok = 1'b0;
        for (int k = 1; k <= BUDGET; k++) begin
            if (k == 4) bus.bin_in = BIN_WIDTH'(mid_value);
            @(posedge clk_100MHz);
            @(negedge clk_100MHz);
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
            if (digits_obs !== last_digits) stable = 1'b0;
        end
        checkOutput("busy_during", busy_ok, 1'b1);
        checkOutput("stable", stable, 1'b1);
        checkOutput("latency", lat, LATENCY);
        checkOutput("busy_at_done", bus.busy, 1'b0);
    endtask

    task automatic verifyResult(input string tag, input int value);
        logic [15:0] expd;
        logic        exp_ovf;
        if (value > 9999) begin
            expd    = 16'hFFFF;
            exp_ovf = 1'b1;
        end else begin
            expd    = {4'(value / 1000), 4'((value / 100) % 10), 4'((value / 10) % 10), 4'(value % 10)};
            exp_ovf = 1'b0;
        end
        checkOutput({tag, "_digits"}, digits_obs, expd);
        checkOutput({tag, "_ovf"}, bus.overflow, exp_ovf);
        last_digits = expd;
    endtask

    initial begin
        logic done_seen;
        bus.start  = 1'b0;
        bus.bin_in = '0;

        repeat (3) @(negedge clk_100MHz);
        checkOutput("rst_digits", digits_obs, 16'h0000);
        checkOutput("rst_busy", bus.busy, 1'b0);
        checkOutput("rst_done", bus.done, 1'b0);
        checkOutput("rst_ovf", bus.overflow, 1'b0);
        reset_n = 1'b1;
        @(negedge clk_100MHz);

        applyStimulus(0, 1'b0, 0, latency);
        verifyResult("zero", 0);
        @(negedge clk_100MHz);
        checkOutput("done_pulse", bus.done, 1'b0);

        applyStimulus(1234, 1'b0, 1234, latency);
        verifyResult("v1234", 1234);
        @(negedge clk_100MHz);
        applyStimulus(9999, 1'b0, 9999, latency);
        verifyResult("v9999", 9999);
        @(negedge clk_100MHz);

        applyStimulus(10000, 1'b0, 10000, latency);
        verifyResult("v10000", 10000);
        @(negedge clk_100MHz);
        checkOutput("ovf_done_pulse", bus.done, 1'b0);
        checkOutput("ovf_held", bus.overflow, 1'b1);
        applyStimulus(42, 1'b0, 42, latency);
        verifyResult("v42", 42);
        @(negedge clk_100MHz);

        // Start held high and bin_in changed mid-conversion, then accepted again on the done cycle.
        applyStimulus(57, 1'b1, 88, latency);
        verifyResult("held57", 57);
        applyStimulus(88, 1'b0, 88, latency);
        verifyResult("b2b88", 88);
        @(negedge clk_100MHz);

        applyStimulus(305, 1'b0, 305, latency);
        verifyResult("v305", 305);
        @(negedge clk_100MHz);
        bus.start  = 1'b1;
        bus.bin_in = BIN_WIDTH'(999);
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        bus.start = 1'b0;
        repeat (4) @(negedge clk_100MHz);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_digits", digits_obs, 16'h0000);
        checkOutput("midrst_busy", bus.busy, 1'b0);
        checkOutput("midrst_ovf", bus.overflow, 1'b0);
        @(negedge clk_100MHz);
        reset_n   = 1'b1;
        done_seen = 1'b0;
        repeat (LATENCY + 5) begin
            @(negedge clk_100MHz);
            if (bus.done === 1'b1) done_seen = 1'b1;
        end
        checkOutput("midrst_no_done", done_seen, 1'b0);
        last_digits = 16'h0000;
        applyStimulus(7, 1'b0, 7, latency);
        verifyResult("v7", 7);
        @(negedge clk_100MHz);

        for (int v = 0; v <= 9999; v += 97) begin
            applyStimulus(v, 1'b0, v, latency);
            verifyResult("sweep", v);
            @(negedge clk_100MHz);
        end
        for (int v = 9990; v <= 10003; v++) begin
            applyStimulus(v, 1'b0, v, latency);
            verifyResult("edge", v);
        end
        applyStimulus(16383, 1'b0, 16383, latency);
        verifyResult("vmax", 16383);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end
endmodule
